// File: rtl/fighter_pkg.sv
// Shared types for the fighter controller: action codes, state field widths and hit bit positions.
package fighter_pkg;
  localparam int ACT_W   = 3;
  localparam int IDX_W   = 3;
  localparam int STATE_W = ACT_W + IDX_W;
  localparam int X_W     = 10;
  localparam int HIT_W   = 4;

  localparam int HIT_P2_PUNCH = 3;
  localparam int HIT_P2_KICK  = 2;
  localparam int HIT_P1_PUNCH = 1;
  localparam int HIT_P1_KICK  = 0;

  typedef enum logic [ACT_W-1:0] {
    ACT_STAY  = 3'd0,
    ACT_FWD   = 3'd1,
    ACT_BACK  = 3'd2,
    ACT_PUNCH = 3'd3,
    ACT_KICK  = 3'd4
  } act_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ANIM = 1'b1
  } anim_st_e;

  // Button nibble is {fwd, back, punch, kick}; earlier buttons win.
  function automatic act_e pick_action(input logic [3:0] btn);
    if (btn[3])      return ACT_FWD;
    else if (btn[2]) return ACT_BACK;
    else if (btn[1]) return ACT_PUNCH;
    else if (btn[0]) return ACT_KICK;
    else             return ACT_STAY;
  endfunction
endpackage

// File: rtl/fighter_if.sv
// Frame-rate control inputs and sprite/hit outputs of the fighter controller.
interface fighter_if;
  import fighter_pkg::*;

  logic               frame_tick;
  logic               run;
  logic               keep;
  logic [7:0]         action;
  logic [X_W-1:0]     p1_x;
  logic [X_W-1:0]     p2_x;
  logic [STATE_W-1:0] p1_state;
  logic [STATE_W-1:0] p2_state;
  logic [HIT_W-1:0]   hit;

  modport master (
    output frame_tick, run, keep, action,
    input  p1_x, p2_x, p1_state, p2_state, hit
  );

  modport slave (
    input  frame_tick, run, keep, action,
    output p1_x, p2_x, p1_state, p2_state, hit
  );
endinterface

// File: rtl/fighter_anim.sv
// Per-player animation FSM with frame delay counter; FIGHTER_COMBO_EN adds a one-entry action queue.
module fighter_anim
  import fighter_pkg::*;
#(
  parameter int FRAMES = 4,
  parameter int DELAY  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clr,
  input  logic [3:0]       btn,
  output act_e             act,
  output logic [IDX_W-1:0] idx,
  output act_e             nxt_act,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             enter
);
  localparam int               DLY_W    = $clog2(DELAY + 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAMES - 1);

  anim_st_e         st_q, st_d;
  act_e             act_q;
  logic [IDX_W-1:0] idx_q;
  logic [DLY_W-1:0] dly_q, dly_d;
  act_e             req;

  assign req = pick_action(btn);

`ifdef FIGHTER_COMBO_EN
  logic q_vld_q, q_vld_d;
  act_e q_act_q, q_act_d;
`endif

  always_comb begin
    st_d    = st_q;
    nxt_act = act_q;
    nxt_idx = idx_q;
    dly_d   = dly_q;
    enter   = 1'b0;
`ifdef FIGHTER_COMBO_EN
    q_vld_d = q_vld_q;
    q_act_d = q_act_q;
`endif
    unique case (st_q)
      ST_IDLE: begin
        nxt_act = req;
        nxt_idx = '0;
        dly_d   = DLY_LOAD;
        if (req != ACT_STAY) begin
          st_d  = ST_ANIM;
          enter = 1'b1;
        end
      end
      ST_ANIM: begin
`ifdef FIGHTER_COMBO_EN
        if (!q_vld_q && req != ACT_STAY) begin
          q_vld_d = 1'b1;
          q_act_d = req;
        end
`endif
        // The frame ends on the tick that would take the delay to zero.
        if (dly_q > DLY_W'(1)) begin
          dly_d = dly_q - 1'b1;
        end else if (idx_q != IDX_LAST) begin
          nxt_idx = idx_q + 1'b1;
          dly_d   = DLY_LOAD;
          enter   = 1'b1;
        end else begin
          st_d    = ST_IDLE;
          nxt_act = ACT_STAY;
          nxt_idx = '0;
          dly_d   = DLY_LOAD;
`ifdef FIGHTER_COMBO_EN
          q_vld_d = 1'b0;
          if (q_vld_q) begin
            st_d    = ST_ANIM;
            nxt_act = q_act_q;
            enter   = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      act_q   <= ACT_STAY;
      idx_q   <= '0;
      dly_q   <= DLY_LOAD;
`ifdef FIGHTER_COMBO_EN
      q_vld_q <= 1'b0;
      q_act_q <= ACT_STAY;
`endif
    end else if (clr) begin
      st_q    <= ST_IDLE;
      act_q   <= ACT_STAY;
      idx_q   <= '0;
      dly_q   <= DLY_LOAD;
`ifdef FIGHTER_COMBO_EN
      q_vld_q <= 1'b0;
      q_act_q <= ACT_STAY;
`endif
    end else if (step) begin
      st_q    <= st_d;
      act_q   <= nxt_act;
      idx_q   <= nxt_idx;
      dly_q   <= dly_d;
`ifdef FIGHTER_COMBO_EN
      q_vld_q <= q_vld_d;
      q_act_q <= q_act_d;
`endif
    end
  end

  assign act = act_q;
  assign idx = idx_q;
endmodule

// File: rtl/fighter_ctrl.sv
// Two-player fighter controller: movement, hit detection and run/keep arbitration around two fighter_anim FSMs.
// Optional FIGHTER_COMBO_EN enables the per-player queued action inside fighter_anim.
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int FRAMES    = 4,
  parameter int DELAY     = 5,
  parameter int SPEED     = 4,
  parameter int BLOCK     = 32,
  parameter int WIDTH     = 64,
  parameter int WALL      = 620,
  parameter int LEFT      = 32,
  parameter int INIT_X1   = 100,
  parameter int INIT_X2   = 425,
  parameter int HIT_FRAME = 2,
  parameter int REACH     = 64
) (
  input logic      clk,
  input logic      rst_n,
  fighter_if.slave bus
);
  localparam logic [X_W-1:0]   X1_INIT = X_W'(INIT_X1);
  localparam logic [X_W-1:0]   X2_INIT = X_W'(INIT_X2);
  localparam logic [X_W-1:0]   X_STEP  = X_W'(SPEED);
  localparam logic [IDX_W-1:0] HIT_IDX = IDX_W'(HIT_FRAME);

  logic             step, clr;
  act_e             p1_act, p2_act, p1_nact, p2_nact;
  logic [IDX_W-1:0] p1_idx, p2_idx, p1_nidx, p2_nidx;
  logic             p1_enter, p2_enter;
  logic [X_W-1:0]   p1_x_q, p2_x_q, p1_x_d, p2_x_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             in_reach;

  // run=0 acts as a soft reset and outranks keep.
  assign clr  = bus.frame_tick & ~bus.run;
  assign step = bus.frame_tick & bus.run & ~bus.keep;

  fighter_anim #(.FRAMES(FRAMES), .DELAY(DELAY)) u_p1_anim (
    .clk(clk), .rst_n(rst_n), .step(step), .clr(clr), .btn(bus.action[7:4]),
    .act(p1_act), .idx(p1_idx), .nxt_act(p1_nact), .nxt_idx(p1_nidx), .enter(p1_enter)
  );

  fighter_anim #(.FRAMES(FRAMES), .DELAY(DELAY)) u_p2_anim (
    .clk(clk), .rst_n(rst_n), .step(step), .clr(clr), .btn(bus.action[3:0]),
    .act(p2_act), .idx(p2_idx), .nxt_act(p2_nact), .nxt_idx(p2_nidx), .enter(p2_enter)
  );

  // p2 is checked against p1's already-moved position so the two never overlap.
  always_comb begin
    p1_x_d = p1_x_q;
    if (p1_nact == ACT_FWD && int'(p1_x_q) + SPEED + BLOCK <= int'(p2_x_q))
      p1_x_d = p1_x_q + X_STEP;
    else if (p1_nact == ACT_BACK && int'(p1_x_q) >= LEFT + SPEED)
      p1_x_d = p1_x_q - X_STEP;

    p2_x_d = p2_x_q;
    if (p2_nact == ACT_FWD && int'(p1_x_d) + BLOCK + SPEED <= int'(p2_x_q))
      p2_x_d = p2_x_q - X_STEP;
    else if (p2_nact == ACT_BACK && int'(p2_x_q) + WIDTH + SPEED <= WALL)
      p2_x_d = p2_x_q + X_STEP;
  end

  assign in_reach = (int'(p2_x_q) - int'(p1_x_q)) < REACH;

  always_comb begin
    hit_d = '0;
    if (in_reach && p1_enter && p1_nidx == HIT_IDX) begin
      hit_d[HIT_P1_PUNCH] = (p1_nact == ACT_PUNCH);
      hit_d[HIT_P1_KICK]  = (p1_nact == ACT_KICK);
    end
    if (in_reach && p2_enter && p2_nidx == HIT_IDX) begin
      hit_d[HIT_P2_PUNCH] = (p2_nact == ACT_PUNCH);
      hit_d[HIT_P2_KICK]  = (p2_nact == ACT_KICK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_x_q <= X1_INIT;
      p2_x_q <= X2_INIT;
      hit_q  <= '0;
    end else if (clr) begin
      p1_x_q <= X1_INIT;
      p2_x_q <= X2_INIT;
      hit_q  <= '0;
    end else if (step) begin
      p1_x_q <= p1_x_d;
      p2_x_q <= p2_x_d;
      hit_q  <= hit_d;
    end else begin
      hit_q  <= '0;
    end
  end

  assign bus.p1_x     = p1_x_q;
  assign bus.p2_x     = p2_x_q;
  assign bus.p1_state = {p1_act, p1_idx};
  assign bus.p2_state = {p2_act, p2_idx};
  assign bus.hit      = hit_q;
endmodule

// File: tb/tb_fighter_ctrl.sv
// Directed bench for fighter_ctrl; p2 starts at x=150 so strikes land within reach.
module tb_fighter_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [3:0] hit_acc;

`ifdef FIGHTER_COMBO_EN
  localparam logic [15:0] COMBO_RET_STATE = 16'd32;
`else
  localparam logic [15:0] COMBO_RET_STATE = 16'd0;
`endif

  always #5 clk = ~clk;

  fighter_if bus ();

  fighter_ctrl #(.INIT_X2(150)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One idle cycle, then a one-cycle frame_tick; returns at the negedge after the tick edge.
  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_b  [5];
    logic [9:0] exp_b2 [5];
    exp_b  = '{10'd104, 10'd108, 10'd112, 10'd116, 10'd116};
    exp_b2 = '{10'd146, 10'd142, 10'd138, 10'd134, 10'd134};

    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.run        = 1'b1;
    bus.keep       = 1'b0;
    bus.action     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_p1_x", 16'(bus.p1_x), 16'd100);
    chk("rst_p2_x", 16'(bus.p2_x), 16'd150);
    chk("rst_p1_state", 16'(bus.p1_state), 16'd0);
    chk("rst_p2_state", 16'(bus.p2_state), 16'd0);
    chk("rst_hit", 16'(bus.hit), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // p1 punch in reach
    bus.action = 8'h20;
    tick();
    chk("a_t1_state", 16'(bus.p1_state), 16'd24);
    hit_acc = bus.hit;
    bus.action = 8'h00;
    for (int t = 2; t <= 21; t++) begin
      tick();
      if (t == 5) chk("a_t5_state", 16'(bus.p1_state), 16'd24);
      if (t == 6) chk("a_t6_state", 16'(bus.p1_state), 16'd25);
      if (t == 16) chk("a_t16_state", 16'(bus.p1_state), 16'd27);
      if (t == 11) begin
        chk("a_t11_state", 16'(bus.p1_state), 16'd26);
        chk("a_t11_hit", 16'(bus.hit), 16'd2);
        @(negedge clk);
        chk("a_hit_clear", 16'(bus.hit), 16'd0);
        chk("a_no_tick_hold", 16'(bus.p1_state), 16'd26);
      end else begin
        hit_acc = hit_acc | bus.hit;
      end
    end
    chk("a_t21_idle", 16'(bus.p1_state), 16'd0);
    chk("a_hit_once", 16'(hit_acc), 16'd0);
    chk("a_p1_x", 16'(bus.p1_x), 16'd100);

    // p1 forward (fwd+punch pressed, fwd wins) up to the blocking gap
    bus.action = 8'hA0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.action = 8'h00;
      if (i == 0) chk("b_state", 16'(bus.p1_state), 16'd8);
      chk("b_p1_x", 16'(bus.p1_x), 16'(exp_b[i]));
    end
    tick();
    chk("b_t6_state", 16'(bus.p1_state), 16'd9);
    chk("b_t6_x", 16'(bus.p1_x), 16'd116);
    chk("b_p2_x", 16'(bus.p2_x), 16'd150);
    bus.run = 1'b0;
    tick();
    chk("run0_p1_x", 16'(bus.p1_x), 16'd100);
    chk("run0_p2_x", 16'(bus.p2_x), 16'd150);
    chk("run0_p1_state", 16'(bus.p1_state), 16'd0);
    bus.run = 1'b1;

    // p2 forward toward p1
    bus.action = 8'h08;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.action = 8'h00;
      if (i == 0) chk("b2_state", 16'(bus.p2_state), 16'd8);
      chk("b2_p2_x", 16'(bus.p2_x), 16'(exp_b2[i]));
    end
    bus.run = 1'b0;
    tick();
    chk("b2_run0_p2_x", 16'(bus.p2_x), 16'd150);
    bus.run = 1'b1;

    // p1 backward into the left limit
    bus.action = 8'h40;
    for (int t = 1; t <= 21; t++) begin
      tick();
      bus.action = 8'h00;
      if (t == 1) chk("c_t1_x", 16'(bus.p1_x), 16'd96);
      if (t == 6) chk("c_t6_state", 16'(bus.p1_state), 16'd17);
      if (t == 17) chk("c_t17_x", 16'(bus.p1_x), 16'd32);
      if (t == 18) chk("c_t18_x", 16'(bus.p1_x), 16'd32);
    end
    chk("c_idle", 16'(bus.p1_state), 16'd0);

    // punch out of reach
    bus.action = 8'h20;
    tick();
    bus.action = 8'h00;
    hit_acc = bus.hit;
    for (int t = 2; t <= 21; t++) begin
      tick();
      hit_acc = hit_acc | bus.hit;
      if (t == 11) chk("d_t11_state", 16'(bus.p1_state), 16'd26);
    end
    chk("d_no_hit", 16'(hit_acc), 16'd0);
    chk("d_idle", 16'(bus.p1_state), 16'd0);
    bus.run = 1'b0;
    tick();
    chk("d_run0_p1_x", 16'(bus.p1_x), 16'd100);
    bus.run = 1'b1;

    // kick with keep freezes
    bus.action = 8'h10;
    tick();
    chk("e_t1_state", 16'(bus.p1_state), 16'd32);
    bus.action = 8'h00;
    tick();
    tick();
    bus.keep = 1'b1;
    repeat (7) tick();
    chk("e_keep_state", 16'(bus.p1_state), 16'd32);
    chk("e_keep_x", 16'(bus.p1_x), 16'd100);
    bus.keep = 1'b0;
    tick();
    tick();
    chk("e_t5_state", 16'(bus.p1_state), 16'd32);
    tick();
    chk("e_t6_state", 16'(bus.p1_state), 16'd33);
    repeat (4) tick();
    bus.keep = 1'b1;
    tick();
    chk("e_keep_hit_state", 16'(bus.p1_state), 16'd33);
    chk("e_keep_hit", 16'(bus.hit), 16'd0);
    bus.keep = 1'b0;
    tick();
    chk("e_t11_state", 16'(bus.p1_state), 16'd34);
    chk("e_t11_hit", 16'(bus.hit), 16'd1);
    bus.action = 8'h04;
    tick();
    chk("e_p2_back_x", 16'(bus.p2_x), 16'd154);
    chk("e_p2_back_state", 16'(bus.p2_state), 16'd16);
    bus.action = 8'h00;
    tick();
    chk("e_p2_back_x2", 16'(bus.p2_x), 16'd158);

    // asynchronous reset mid-animation
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_p1_x", 16'(bus.p1_x), 16'd100);
    chk("ar_p2_x", 16'(bus.p2_x), 16'd150);
    chk("ar_p1_state", 16'(bus.p1_state), 16'd0);
    chk("ar_p2_state", 16'(bus.p2_state), 16'd0);
    chk("ar_hit", 16'(bus.hit), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.action = 8'h20;
    tick();
    chk("ar_launch", 16'(bus.p1_state), 16'd24);
    bus.action = 8'h00;
    repeat (4) tick();
    chk("ar_t5_state", 16'(bus.p1_state), 16'd24);
    tick();
    chk("ar_t6_state", 16'(bus.p1_state), 16'd25);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;

    // p2 punch with a kick pressed mid-animation
    bus.action = 8'h02;
    tick();
    chk("f_t1_state", 16'(bus.p2_state), 16'd24);
    bus.action = 8'h00;
    tick();
    bus.action = 8'h01;
    tick();
    bus.action = 8'h00;
    for (int t = 4; t <= 21; t++) begin
      tick();
      if (t == 11) chk("f_t11_hit", 16'(bus.hit), 16'd8);
    end
    chk("f_return_state", 16'(bus.p2_state), COMBO_RET_STATE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
